// File: rtl/mul_div_issue_arbiter.sv
// Two-lane oldest-first issue arbiter in front of the shared mul/div unit.
// One holding buffer per lane, ROB-age selection, flush drop, grant counters.
module mul_div_issue_arbiter #(
    parameter int PAYLOAD_W = 256,
    parameter int ROB_W     = 4,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 flush,
    input  logic [ROB_W-1:0]     rob_head,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [ROB_W-1:0]     req0_rob,
    input  logic [PAYLOAD_W-1:0] req0_payload,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [ROB_W-1:0]     req1_rob,
    input  logic [PAYLOAD_W-1:0] req1_payload,
    output logic                 out_valid,
    input  logic                 unit_allowin,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [ROB_W-1:0]     out_rob,
    output logic                 out_lane,
    output logic [CNT_W-1:0]     grant_cnt0,
    output logic [CNT_W-1:0]     grant_cnt1
);

    logic                 buf0_valid_q, buf0_valid_d;
    logic                 buf1_valid_q, buf1_valid_d;
    logic [ROB_W-1:0]     buf0_rob_q, buf0_rob_d;
    logic [ROB_W-1:0]     buf1_rob_q, buf1_rob_d;
    logic [PAYLOAD_W-1:0] buf0_pay_q, buf0_pay_d;
    logic [PAYLOAD_W-1:0] buf1_pay_q, buf1_pay_d;
    logic [CNT_W-1:0]     cnt0_q, cnt0_d;
    logic [CNT_W-1:0]     cnt1_q, cnt1_d;

    logic [ROB_W-1:0] age0, age1;
    logic             any_valid, sel1, grant, gnt0, gnt1, acc0, acc1;

    // Modular distance from the ROB head handles wrap-around for free.
    assign age0 = buf0_rob_q - rob_head;
    assign age1 = buf1_rob_q - rob_head;

    assign any_valid = buf0_valid_q | buf1_valid_q;
    assign sel1      = buf1_valid_q & (!buf0_valid_q | (age1 < age0));

    assign out_valid   = any_valid & !flush;
    assign out_lane    = any_valid & sel1;
    assign out_rob     = !any_valid ? '0 : (sel1 ? buf1_rob_q : buf0_rob_q);
    assign out_payload = !any_valid ? '0 : (sel1 ? buf1_pay_q : buf0_pay_q);

    assign grant = out_valid & unit_allowin;
    assign gnt0  = grant & !sel1;
    assign gnt1  = grant & sel1;

    assign req0_ready = !flush & (!buf0_valid_q | gnt0);
    assign req1_ready = !flush & (!buf1_valid_q | gnt1);
    assign acc0       = req0_valid & req0_ready;
    assign acc1       = req1_valid & req1_ready;

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;

    always_comb begin
        buf0_valid_d = flush ? 1'b0 : ((buf0_valid_q & !gnt0) | acc0);
        buf1_valid_d = flush ? 1'b0 : ((buf1_valid_q & !gnt1) | acc1);
        buf0_rob_d   = acc0 ? req0_rob : buf0_rob_q;
        buf1_rob_d   = acc1 ? req1_rob : buf1_rob_q;
        buf0_pay_d   = acc0 ? req0_payload : buf0_pay_q;
        buf1_pay_d   = acc1 ? req1_payload : buf1_pay_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        if (gnt0 && (cnt0_q != '1)) cnt0_d = cnt0_q + 1'b1;
        if (gnt1 && (cnt1_q != '1)) cnt1_d = cnt1_q + 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            buf0_valid_q <= 1'b0;
            buf1_valid_q <= 1'b0;
            buf0_rob_q   <= '0;
            buf1_rob_q   <= '0;
            buf0_pay_q   <= '0;
            buf1_pay_q   <= '0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            buf0_valid_q <= buf0_valid_d;
            buf1_valid_q <= buf1_valid_d;
            buf0_rob_q   <= buf0_rob_d;
            buf1_rob_q   <= buf1_rob_d;
            buf0_pay_q   <= buf0_pay_d;
            buf1_pay_q   <= buf1_pay_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

endmodule

// File: tb/tb_mul_div_issue_arbiter.sv
// Directed bench for mul_div_issue_arbiter.
// Uses a 4-bit grant counter so saturation is reachable quickly.
module tb_mul_div_issue_arbiter;

    localparam int PW = 32;
    localparam int RW = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          resetn, flush, unit_allowin;
    logic [RW-1:0] rob_head;
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    logic [RW-1:0] req0_rob, req1_rob, out_rob;
    logic [PW-1:0] req0_payload, req1_payload, out_payload;
    logic          out_valid, out_lane;
    logic [CW-1:0] grant_cnt0, grant_cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_div_issue_arbiter #(.PAYLOAD_W(PW), .ROB_W(RW), .CNT_W(CW)) dut (
        .clk(clk), .resetn(resetn), .flush(flush), .rob_head(rob_head),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_rob(req0_rob), .req0_payload(req0_payload),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_rob(req1_rob), .req1_payload(req1_payload),
        .out_valid(out_valid), .unit_allowin(unit_allowin),
        .out_payload(out_payload), .out_rob(out_rob), .out_lane(out_lane),
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; flush = 1'b0; unit_allowin = 1'b0; rob_head = '0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_rob = '0; req1_rob = '0; req0_payload = '0; req1_payload = '0;
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (out_rob !== 4'd0 || out_lane !== 1'b0 || out_payload !== 32'd0) begin errors++; $display("FAIL reset_out_fields got rob=%0d lane=%b pay=%h exp 0", out_rob, out_lane, out_payload); end
        checks++; if (grant_cnt0 !== 4'd0 || grant_cnt1 !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", grant_cnt0, grant_cnt1); end
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b%b exp 11", req0_ready, req1_ready); end
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_single();
        rob_head = 4'd0; unit_allowin = 1'b1;
        req0_valid = 1'b1; req0_rob = 4'd3; req0_payload = 32'hA000_0003;
        tick();
        req0_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1 || out_rob !== 4'd3 || out_lane !== 1'b0 || out_payload !== 32'hA000_0003) begin errors++; $display("FAIL single_offer got v=%b rob=%0d lane=%b pay=%h exp 1/3/0/a0000003", out_valid, out_rob, out_lane, out_payload); end
        tick();
        checks++; if (out_valid !== 1'b0 || grant_cnt0 !== 4'd1) begin errors++; $display("FAIL single_grant got v=%b cnt0=%0d exp 0/1", out_valid, grant_cnt0); end
    endtask

    task automatic test_both();
        rob_head = 4'd0; unit_allowin = 1'b1;
        req0_valid = 1'b1; req0_rob = 4'd5; req0_payload = 32'hB000_0005;
        req1_valid = 1'b1; req1_rob = 4'd2; req1_payload = 32'hC000_0002;
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        checks++; if (out_lane !== 1'b1 || out_rob !== 4'd2 || out_payload !== 32'hC000_0002) begin errors++; $display("FAIL both_first got lane=%b rob=%0d exp 1/2", out_lane, out_rob); end
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin errors++; $display("FAIL both_ready got %b%b exp 01", req0_ready, req1_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_lane !== 1'b0 || out_rob !== 4'd5 || grant_cnt1 !== 4'd1) begin errors++; $display("FAIL both_second got v=%b lane=%b rob=%0d cnt1=%0d exp 1/0/5/1", out_valid, out_lane, out_rob, grant_cnt1); end
        tick();
        checks++; if (out_valid !== 1'b0 || grant_cnt0 !== 4'd2) begin errors++; $display("FAIL both_done got v=%b cnt0=%0d exp 0/2", out_valid, grant_cnt0); end
    endtask

    task automatic test_wrap(input logic [RW-1:0] head, input logic exp_first,
                             input logic [CW-1:0] exp_c0, input logic [CW-1:0] exp_c1);
        rob_head = head; unit_allowin = 1'b1;
        req0_valid = 1'b1; req0_rob = 4'd1;  req0_payload = 32'hD000_0001;
        req1_valid = 1'b1; req1_rob = 4'd15; req1_payload = 32'hD000_000F;
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        checks++; if (out_lane !== exp_first) begin errors++; $display("FAIL wrap_first head=%0d got lane=%b exp %b", head, out_lane, exp_first); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_lane !== !exp_first) begin errors++; $display("FAIL wrap_second head=%0d got v=%b lane=%b exp 1/%b", head, out_valid, out_lane, !exp_first); end
        tick();
        checks++; if (grant_cnt0 !== exp_c0 || grant_cnt1 !== exp_c1) begin errors++; $display("FAIL wrap_cnt head=%0d got %0d/%0d exp %0d/%0d", head, grant_cnt0, grant_cnt1, exp_c0, exp_c1); end
    endtask

    task automatic test_backpressure();
        rob_head = 4'd0; unit_allowin = 1'b0;
        req0_valid = 1'b1; req0_rob = 4'd4; req0_payload = 32'hD0D0_0004;
        req1_valid = 1'b1; req1_rob = 4'd6; req1_payload = 32'hE0E0_0006;
        tick();
        req0_rob = 4'd7; req0_payload = 32'hF0F0_0007;
        req1_rob = 4'd8; req1_payload = 32'h6060_0008;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || out_payload !== 32'hD0D0_0004 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold cyc=%0d got rdy=%b%b v=%b pay=%h exp 00/1/d0d00004", i, req0_ready, req1_ready, out_valid, out_payload); end
            tick();
        end
        unit_allowin = 1'b1;
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL bp_release_ready got %b%b exp 10", req0_ready, req1_ready); end
        tick();
        req0_valid = 1'b0;
        #1;
        checks++; if (out_lane !== 1'b1 || out_payload !== 32'hE0E0_0006 || grant_cnt0 !== 4'd5) begin errors++; $display("FAIL bp_next got lane=%b pay=%h cnt0=%0d exp 1/e0e00006/5", out_lane, out_payload, grant_cnt0); end
        tick();
        req1_valid = 1'b0; unit_allowin = 1'b0;
        #1;
        checks++; if (out_lane !== 1'b0 || out_payload !== 32'hF0F0_0007 || grant_cnt1 !== 4'd4) begin errors++; $display("FAIL bp_refill got lane=%b pay=%h cnt1=%0d exp 0/f0f00007/4", out_lane, out_payload, grant_cnt1); end
    endtask

    task automatic test_flush();
        unit_allowin = 1'b1; flush = 1'b1;
        req0_valid = 1'b1; req0_rob = 4'd9; req0_payload = 32'h9999_0009;
        #1;
        checks++; if (out_valid !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL flush_cycle got v=%b rdy=%b%b exp 0/00", out_valid, req0_ready, req1_ready); end
        tick();
        flush = 1'b0; req0_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || req0_ready !== 1'b1 || req1_ready !== 1'b1) begin errors++; $display("FAIL flush_after got v=%b rdy=%b%b exp 0/11", out_valid, req0_ready, req1_ready); end
        checks++; if (grant_cnt0 !== 4'd5 || grant_cnt1 !== 4'd4) begin errors++; $display("FAIL flush_cnt got %0d/%0d exp 5/4", grant_cnt0, grant_cnt1); end
    endtask

    task automatic test_async_reset();
        unit_allowin = 1'b0;
        req0_valid = 1'b1; req0_rob = 4'd3; req0_payload = 32'h3333_0003;
        tick();
        req0_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ares_pre got v=%b exp 1", out_valid); end
        resetn = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_rob !== 4'd0 || out_payload !== 32'd0 || out_lane !== 1'b0) begin errors++; $display("FAIL ares_out got v=%b rob=%0d pay=%h exp 0/0/0", out_valid, out_rob, out_payload); end
        checks++; if (grant_cnt0 !== 4'd0 || grant_cnt1 !== 4'd0 || req0_ready !== 1'b1 || req1_ready !== 1'b1) begin errors++; $display("FAIL ares_cnt got %0d/%0d rdy=%b%b exp 0/0/11", grant_cnt0, grant_cnt1, req0_ready, req1_ready); end
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back_saturation();
        rob_head = 4'd0; unit_allowin = 1'b1;
        req1_valid = 1'b1; req1_rob = 4'd1;
        for (int i = 0; i < 21; i++) begin
            req1_payload = 32'h5A00_0000 + i;
            tick();
            checks++; if (out_valid !== 1'b1 || out_payload !== 32'h5A00_0000 + i) begin errors++; $display("FAIL b2b_flow i=%0d got v=%b pay=%h exp 1/%h", i, out_valid, out_payload, 32'h5A00_0000 + i); end
            if (i == 15) begin
                checks++; if (grant_cnt1 !== 4'd15) begin errors++; $display("FAIL sat_reach got %0d exp 15", grant_cnt1); end
            end
        end
        req1_valid = 1'b0;
        checks++; if (grant_cnt1 !== 4'd15 || grant_cnt0 !== 4'd0) begin errors++; $display("FAIL sat_hold got %0d/%0d exp 0/15", grant_cnt0, grant_cnt1); end
        tick();
        checks++; if (grant_cnt1 !== 4'd15 || out_valid !== 1'b0) begin errors++; $display("FAIL sat_final got cnt1=%0d v=%b exp 15/0", grant_cnt1, out_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_both();
        test_wrap(4'd14, 1'b1, 4'd3, 4'd2);
        test_wrap(4'd0,  1'b0, 4'd4, 4'd3);
        test_backpressure();
        test_flush();
        test_async_reset();
        test_back_to_back_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
